// File: rtl/nios_timer_seq_pkg.sv
// Shared definitions for the Avalon interval-timer sequencer.
// Holds timer register addresses, control-word bits, the sequencer FSM
// state type and a small helper that builds one Avalon write.
// Optional feature macro used by the top: TIMER_SEQ_CANCEL_EN.
package nios_timer_seq_pkg;

    // Timer register map (16-bit registers)
    localparam logic [2:0] TMR_STATUS  = 3'd0;
    localparam logic [2:0] TMR_CONTROL = 3'd1;
    localparam logic [2:0] TMR_PERL    = 3'd2;
    localparam logic [2:0] TMR_PERH    = 3'd3;

    // Timer control-register bits
    localparam logic [15:0] CTRL_ITO   = 16'h0001;
    localparam logic [15:0] CTRL_START = 16'h0004;
    localparam logic [15:0] CTRL_STOP  = 16'h0008;

    // Width of a channel index (NCH is at most 8)
    localparam int CH_W = 3;

    // Each write state is named after the bus cycle it presents: while the
    // FSM sits in a write state, that write is on the Avalon bus.
    typedef enum logic [3:0] {
        ST_BOOT,
        ST_INIT_STOP,
        ST_INIT_CLR,
        ST_IDLE,
        ST_CLR,
        ST_WR_PL,
        ST_WR_PH,
        ST_WR_CTRL,
        ST_WAIT,
        ST_ACK,
        ST_CAN_STOP,
        ST_CAN_CLR
    } seq_state_t;

    // One registered Avalon master cycle
    typedef struct packed {
        logic        cs;
        logic        wr_n;
        logic [2:0]  addr;
        logic [15:0] data;
    } av_bus_t;

    localparam av_bus_t AV_IDLE = '{cs: 1'b0, wr_n: 1'b1, addr: 3'd0, data: 16'h0000};

    // Build a single-cycle write to the timer
    function automatic av_bus_t av_wr(input logic [2:0] addr, input logic [15:0] data);
        av_bus_t b;
        b.cs   = 1'b1;
        b.wr_n = 1'b0;
        b.addr = addr;
        b.data = data;
        return b;
    endfunction

    // Timer counts period_reg+1 cycles, so program period-1.
    // Periods below 2 are treated as 2 to keep the load non-zero.
    function automatic logic [31:0] load_from_period(input logic [31:0] p);
        logic [31:0] l;
        if (p < 32'd2) begin
            l = 32'd1;
        end else begin
            l = p - 32'd1;
        end
        return l;
    endfunction

endpackage

// File: rtl/nios_timer_seq_rr_arb.sv
// Round-robin arbiter for the timer sequencer.
// Searches the pending vector starting at ptr and wrapping at NCH; returns
// a one-hot grant plus the winning index. Grant is forced to zero when
// enable is low.
module nios_timer_seq_rr_arb
    import nios_timer_seq_pkg::*;
#(
    parameter int NCH = 4
) (
    input  logic [NCH-1:0]  pending,
    input  logic [CH_W-1:0] ptr,
    input  logic            enable,
    output logic [NCH-1:0]  grant,
    output logic [CH_W-1:0] grant_idx
);

    localparam int SW = CH_W + 1;

    logic [NCH-1:0]  rot;
    logic [CH_W-1:0] off;
    logic            found;
    logic [SW-1:0]   sum;

    // Rotate pending so that bit 0 is the highest-priority channel
    assign rot = NCH'({pending, pending} >> ptr);

    // Find the first requester at or after the pointer
    always_comb begin
        found = 1'b0;
        off   = '0;
        for (int k = 0; k < NCH; k++) begin
            if (!found && rot[k]) begin
                found = 1'b1;
                off   = CH_W'(k);
            end
        end
    end

    // Map the rotated offset back to an absolute channel index
    always_comb begin
        sum = {1'b0, ptr} + {1'b0, off};
        if (sum >= SW'(NCH)) begin
            sum = sum - SW'(NCH);
        end
    end

    assign grant_idx = sum[CH_W-1:0];

    generate
        for (genvar gi = 0; gi < NCH; gi++) begin : g_grant
            assign grant[gi] = enable && found && (grant_idx == CH_W'(gi));
        end
    endgenerate

endmodule

// File: rtl/nios_timer_sequencer.sv
// Shares one Avalon interval timer among NCH one-shot timeout requesters.
// Requests are captured per channel, arbitrated round-robin, and the winner
// programs the timer (clear, period lo/hi, start with irq). On timer_irq the
// irq is acknowledged and done[ch] pulses.
// Optional feature: define TIMER_SEQ_CANCEL_EN to add cancel/cancelled ports,
// allowing a pending request to be dropped or an owned timer to be stopped.
module nios_timer_sequencer
    import nios_timer_seq_pkg::*;
#(
    parameter int NCH  = 4,
    parameter int PERW = 32
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [NCH-1:0]      req,
    input  logic [NCH*PERW-1:0] period,
`ifdef TIMER_SEQ_CANCEL_EN
    input  logic [NCH-1:0]      cancel,
    output logic [NCH-1:0]      cancelled,
`endif
    output logic [NCH-1:0]      done,
    output logic [NCH-1:0]      pending,
    output logic                active,
    output logic [2:0]          active_ch,
    output logic [2:0]          av_address,
    output logic                av_chipselect,
    output logic                av_write_n,
    output logic [15:0]         av_writedata,
    input  logic                timer_irq
);

    // Only the low 32 period bits reach the 32-bit timer load
    localparam int PW_USE = (PERW < 32) ? PERW : 32;

    seq_state_t      state_reg;
    av_bus_t         bus_reg;
    logic [NCH-1:0]  pending_reg;
    logic [NCH-1:0]  done_reg;
    logic            active_reg;
    logic [CH_W-1:0] active_ch_reg;
    logic [CH_W-1:0] ptr_reg;
    logic [31:0]     load_reg [NCH];

    logic [NCH-1:0]  grant;
    logic [CH_W-1:0] grant_idx;
    logic [NCH-1:0]  capture;
    logic [NCH-1:0]  own_mask;
    logic [NCH-1:0]  cancel_i;
    logic [NCH-1:0]  cancel_pend;
    logic            cancel_own;
    logic [31:0]     load_sel;
    logic            arb_en;

`ifdef TIMER_SEQ_CANCEL_EN
    logic [NCH-1:0]  cancelled_reg;
    assign cancel_i  = cancel;
    assign cancelled = cancelled_reg;
`else
    assign cancel_i  = '0;
`endif

    // A request is accepted only when the channel is neither waiting nor
    // currently owning the timer; later requests never overwrite the period.
    generate
        for (genvar gi = 0; gi < NCH; gi++) begin : g_chan
            assign own_mask[gi] = active_reg && (active_ch_reg == CH_W'(gi));
            assign capture[gi]  = req[gi] && !pending_reg[gi] && !own_mask[gi];
        end
    endgenerate

    // Cancelling a waiting channel is ignored in its grant cycle: it already owns the timer
    assign cancel_pend = cancel_i & pending_reg & ~grant;
    assign cancel_own  = |(cancel_i & own_mask);

    assign arb_en = (state_reg == ST_IDLE);

    nios_timer_seq_rr_arb #(
        .NCH (NCH)
    ) u_arb (
        .pending   (pending_reg),
        .ptr       (ptr_reg),
        .enable    (arb_en),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    // Per-channel load value, stored already saturated and decremented
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int c = 0; c < NCH; c++) begin
                load_reg[c] <= '0;
            end
        end else begin
            for (int c = 0; c < NCH; c++) begin
                if (capture[c]) begin
                    load_reg[c] <= load_from_period(32'(period[c*PERW +: PW_USE])); // zero-extends narrow periods
                end
            end
        end
    end

    // Select the owning channel's load value
    always_comb begin
        load_sel = '0;
        for (int c = 0; c < NCH; c++) begin
            if (active_ch_reg == CH_W'(c)) begin
                load_sel = load_reg[c];
            end
        end
    end

    // Pending bits: set on capture, cleared on grant or cancel
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pending_reg <= '0;
        end else begin
            pending_reg <= (pending_reg & ~grant & ~cancel_pend) | capture;
        end
    end

    // Sequencer FSM; bus_reg is loaded with the write belonging to the next state
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg     <= ST_BOOT;
            bus_reg       <= AV_IDLE;
            done_reg      <= '0;
            active_reg    <= 1'b0;
            active_ch_reg <= '0;
            ptr_reg       <= '0;
`ifdef TIMER_SEQ_CANCEL_EN
            cancelled_reg <= '0;
`endif
        end else begin
            bus_reg  <= AV_IDLE;
            done_reg <= '0;
`ifdef TIMER_SEQ_CANCEL_EN
            cancelled_reg <= cancel_pend;
`endif
            case (state_reg)
                ST_BOOT: begin
                    // A timer left running from before reset gets stopped first
                    state_reg <= ST_INIT_STOP;
                    bus_reg   <= av_wr(TMR_CONTROL, CTRL_STOP);
                end
                ST_INIT_STOP: begin
                    state_reg <= ST_INIT_CLR;
                    bus_reg   <= av_wr(TMR_STATUS, 16'h0000);
                end
                ST_INIT_CLR: begin
                    state_reg <= ST_IDLE;
                end
                ST_IDLE: begin
                    if (|grant) begin
                        active_reg    <= 1'b1;
                        active_ch_reg <= grant_idx;
                        ptr_reg       <= (grant_idx == CH_W'(NCH - 1)) ? '0 : grant_idx + CH_W'(1);
                        state_reg     <= ST_CLR;
                        bus_reg       <= av_wr(TMR_STATUS, 16'h0000);
                    end
                end
                ST_CLR: begin
                    // A cancel here still lets the clear write complete first
                    if (cancel_own) begin
                        state_reg <= ST_CAN_STOP;
                        bus_reg   <= av_wr(TMR_CONTROL, CTRL_STOP);
                    end else begin
                        state_reg <= ST_WR_PL;
                        bus_reg   <= av_wr(TMR_PERL, load_sel[15:0]);
                    end
                end
                ST_WR_PL: begin
                    if (cancel_own) begin
                        state_reg <= ST_CAN_STOP;
                        bus_reg   <= av_wr(TMR_CONTROL, CTRL_STOP);
                    end else begin
                        state_reg <= ST_WR_PH;
                        bus_reg   <= av_wr(TMR_PERH, load_sel[31:16]);
                    end
                end
                ST_WR_PH: begin
                    if (cancel_own) begin
                        state_reg <= ST_CAN_STOP;
                        bus_reg   <= av_wr(TMR_CONTROL, CTRL_STOP);
                    end else begin
                        state_reg <= ST_WR_CTRL;
                        bus_reg   <= av_wr(TMR_CONTROL, CTRL_START | CTRL_ITO);
                    end
                end
                ST_WR_CTRL: begin
                    if (cancel_own) begin
                        state_reg <= ST_CAN_STOP;
                        bus_reg   <= av_wr(TMR_CONTROL, CTRL_STOP);
                    end else begin
                        state_reg <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    // Cancel takes precedence over a simultaneous irq
                    if (cancel_own) begin
                        state_reg <= ST_CAN_STOP;
                        bus_reg   <= av_wr(TMR_CONTROL, CTRL_STOP);
                    end else if (timer_irq) begin
                        state_reg <= ST_ACK;
                        bus_reg   <= av_wr(TMR_STATUS, 16'h0000);
                        done_reg  <= own_mask;
                    end
                end
                ST_ACK: begin
                    active_reg <= 1'b0;
                    state_reg  <= ST_IDLE;
                end
                ST_CAN_STOP: begin
                    state_reg <= ST_CAN_CLR;
                    bus_reg   <= av_wr(TMR_STATUS, 16'h0000);
`ifdef TIMER_SEQ_CANCEL_EN
                    cancelled_reg <= cancel_pend | own_mask;
`endif
                end
                ST_CAN_CLR: begin
                    active_reg <= 1'b0;
                    state_reg  <= ST_IDLE;
                end
                default: begin
                    state_reg <= ST_BOOT;
                end
            endcase
        end
    end

    assign done          = done_reg;
    assign pending       = pending_reg;
    assign active        = active_reg;
    assign active_ch     = active_ch_reg;
    assign av_chipselect = bus_reg.cs;
    assign av_write_n    = bus_reg.wr_n;
    assign av_address    = bus_reg.addr;
    assign av_writedata  = bus_reg.data;

endmodule

// File: tb/tb_nios_timer_sequencer.sv
// Directed bench for nios_timer_sequencer paired with a behavioural model
// of the Avalon interval timer. Cancel scenario runs when
// TIMER_SEQ_CANCEL_EN is defined.
module tb_nios_timer_sequencer;

    localparam int NCH  = 4;
    localparam int PERW = 32;

    logic                clk = 1'b0;
    logic                reset_n = 1'b0;
    logic [NCH-1:0]      req = '0;
    logic [NCH*PERW-1:0] period = '0;
    logic [NCH-1:0]      done;
    logic [NCH-1:0]      pending;
    logic                active;
    logic [2:0]          active_ch;
    logic [2:0]          av_address;
    logic                av_chipselect;
    logic                av_write_n;
    logic [15:0]         av_writedata;
    logic                timer_irq;
`ifdef TIMER_SEQ_CANCEL_EN
    logic [NCH-1:0]      cancel = '0;
    logic [NCH-1:0]      cancelled;
`endif

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int req_cyc  = 0;

    nios_timer_sequencer #(
        .NCH  (NCH),
        .PERW (PERW)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .req           (req),
        .period        (period),
`ifdef TIMER_SEQ_CANCEL_EN
        .cancel        (cancel),
        .cancelled     (cancelled),
`endif
        .done          (done),
        .pending       (pending),
        .active        (active),
        .active_ch     (active_ch),
        .av_address    (av_address),
        .av_chipselect (av_chipselect),
        .av_write_n    (av_write_n),
        .av_writedata  (av_writedata),
        .timer_irq     (timer_irq)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Interval timer model: period N counts N+1 cycles, one-shot, irq = TO & ITO
    logic [15:0] t_perl, t_perh;
    logic [31:0] t_cnt;
    logic        t_run, t_to, t_ito;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            t_perl <= '0; t_perh <= '0; t_cnt <= '0;
            t_run  <= 1'b0; t_to <= 1'b0; t_ito <= 1'b0;
        end else if (av_chipselect && !av_write_n) begin
            case (av_address)
                3'd0: t_to <= 1'b0;
                3'd1: begin
                    t_ito <= av_writedata[0];
                    if (av_writedata[3]) begin
                        t_run <= 1'b0;
                    end else if (av_writedata[2]) begin
                        t_run <= 1'b1;
                        t_cnt <= {t_perh, t_perl};
                    end
                end
                3'd2: t_perl <= av_writedata;
                3'd3: t_perh <= av_writedata;
                default: ;
            endcase
        end else if (t_run) begin
            if (t_cnt == 32'd0) begin
                t_to  <= 1'b1;
                t_run <= 1'b0;
            end else begin
                t_cnt <= t_cnt - 32'd1;
            end
        end
    end

    assign timer_irq = t_to & t_ito;

    // Bus / event monitor, sampled on the falling edge
    typedef struct packed {
        logic [2:0]  addr;
        logic [15:0] data;
        logic [31:0] wcyc;
    } wr_t;

    wr_t wr_q[$];
    int  done_ch_q[$];
    int  done_cyc_q[$];
    int  canc_ch_q[$];

    always @(negedge clk) begin
        if (reset_n && av_chipselect && !av_write_n) begin
            wr_q.push_back('{addr: av_address, data: av_writedata, wcyc: 32'(cyc)});
            $display("cyc %0d write addr=%0d data=%04h", cyc, av_address, av_writedata);
        end
        for (int i = 0; i < NCH; i++) begin
            if (done[i]) begin
                done_ch_q.push_back(i);
                done_cyc_q.push_back(cyc);
                $display("cyc %0d done ch=%0d", cyc, i);
            end
`ifdef TIMER_SEQ_CANCEL_EN
            if (cancelled[i]) begin
                canc_ch_q.push_back(i);
                $display("cyc %0d cancelled ch=%0d", cyc, i);
            end
`endif
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] wr_word(input int idx);
        if (idx < wr_q.size()) return {13'd0, wr_q[idx].addr, wr_q[idx].data};
        return 32'hDEAD_BEEF;
    endfunction

    function automatic int wr_cyc(input int idx);
        if (idx < wr_q.size()) return int'(wr_q[idx].wcyc);
        return -1000;
    endfunction

    function automatic int done_ch(input int idx);
        if (idx < done_ch_q.size()) return done_ch_q[idx];
        return 99;
    endfunction

    task automatic chk_wr(input string tag, input int idx, input logic [2:0] a, input logic [15:0] d);
        chk(tag, wr_word(idx), {13'd0, a, d});
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic flush();
        wr_q.delete();
        done_ch_q.delete();
        done_cyc_q.delete();
        canc_ch_q.delete();
    endtask

    task automatic set_period(input int ch, input logic [31:0] p);
        period[ch*PERW +: PERW] = p;
    endtask

    // One-cycle request pulse; checks that the channels became pending
    task automatic issue(input logic [NCH-1:0] m);
        @(posedge clk); #1;
        req     = m;
        req_cyc = cyc;
        @(posedge clk); #1;
        req = '0;
        chk("pending_set", 32'(pending & m), 32'(m));
    endtask

    task automatic wait_dones(input string tag, input int n, input int budget);
        int k = 0;
        while (done_ch_q.size() < n && k < budget) begin
            @(posedge clk);
            k++;
        end
        #1;
        chk(tag, 32'(done_ch_q.size()), 32'(n));
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        req     = '0;
        tick(3);
        chk("rst_ctl", 32'({done, pending, active, active_ch, av_address, av_chipselect, av_write_n}),
            32'({4'h0, 4'h0, 1'b0, 3'd0, 3'd0, 1'b0, 1'b1}));
        chk("rst_wdata", 32'(av_writedata), 32'd0);
        flush();
        reset_n = 1'b1;
        tick(8);
        chk("init_nwr", 32'(wr_q.size()), 32'd2);
        chk_wr("init_stop", 0, 3'd1, 16'h0008);
        chk_wr("init_clr", 1, 3'd0, 16'h0000);
        chk("init_nodone", 32'(done_ch_q.size()), 32'd0);
        flush();
    endtask

    initial begin
        // 1: reset behaviour and init writes
        do_reset();

        // 2: single request, period 100 then 101
        set_period(0, 32'd100);
        issue(4'b0001);
        wait_dones("p100_done", 1, 400);
        chk_wr("p100_clr", 0, 3'd0, 16'h0000);
        chk_wr("p100_pl", 1, 3'd2, 16'h0063);
        chk_wr("p100_ph", 2, 3'd3, 16'h0000);
        chk_wr("p100_ctrl", 3, 3'd1, 16'h0005);
        chk_wr("p100_ack", 4, 3'd0, 16'h0000);
        chk("p100_clr_lat", 32'(wr_cyc(0) - req_cyc), 32'd2);
        chk("p100_ctrl_lat", 32'(wr_cyc(3) - req_cyc), 32'd5);
        chk("p100_done_ofs", 32'(done_cyc_q[0] - wr_cyc(3)), 32'd102);
        chk("p100_done_ch", 32'(done_ch(0)), 32'd0);
        tick(3);
        chk("p100_inactive", 32'(active), 32'd0);
        flush();

        set_period(0, 32'd101);
        issue(4'b0001);
        wait_dones("p101_done", 1, 400);
        chk_wr("p101_pl", 1, 3'd2, 16'h0064);
        chk("p101_done_ofs", 32'(done_cyc_q[0] - wr_cyc(3)), 32'd103);
        tick(3);
        flush();

        // 3: round-robin order from reset, then wrap after ch3
        do_reset();
        for (int i = 0; i < NCH; i++) set_period(i, 32'd10);
        issue(4'b1111);
        wait_dones("rr4_done", 4, 400);
        chk("rr4_o0", 32'(done_ch(0)), 32'd0);
        chk("rr4_o1", 32'(done_ch(1)), 32'd1);
        chk("rr4_o2", 32'(done_ch(2)), 32'd2);
        chk("rr4_o3", 32'(done_ch(3)), 32'd3);
        tick(3);
        flush();
        issue(4'b0101);
        wait_dones("rr2_done", 2, 300);
        chk("rr2_o0", 32'(done_ch(0)), 32'd0);
        chk("rr2_o1", 32'(done_ch(1)), 32'd2);
        tick(3);
        flush();

        // 4: boundary periods
        set_period(1, 32'h0001_0000);
        issue(4'b0010);
        wait_dones("big_done", 1, 66000);
        chk_wr("big_pl", 1, 3'd2, 16'hFFFF);
        chk_wr("big_ph", 2, 3'd3, 16'h0000);
        chk("big_done_ofs", 32'(done_cyc_q[0] - wr_cyc(3)), 32'h0001_0002);
        tick(3);
        flush();

        set_period(2, 32'd0);
        issue(4'b0100);
        wait_dones("p0_done", 1, 100);
        chk_wr("p0_pl", 1, 3'd2, 16'h0001);
        chk_wr("p0_ph", 2, 3'd3, 16'h0000);
        chk("p0_done_ofs", 32'(done_cyc_q[0] - wr_cyc(3)), 32'd4);
        tick(3);
        flush();

        set_period(3, 32'd1);
        issue(4'b1000);
        wait_dones("p1_done", 1, 100);
        chk_wr("p1_pl", 1, 3'd2, 16'h0001);
        tick(3);
        flush();

        // 5: second request while pending is ignored
        set_period(1, 32'd20);
        @(posedge clk); #1;
        req = 4'b0010;
        @(posedge clk); #1;
        set_period(1, 32'd50);
        @(posedge clk); #1;
        req = '0;
        wait_dones("dup_done", 1, 200);
        tick(80);
        chk("dup_ndone", 32'(done_ch_q.size()), 32'd1);
        chk("dup_ch", 32'(done_ch(0)), 32'd1);
        chk_wr("dup_pl", 1, 3'd2, 16'h0013);
        chk("dup_nwr", 32'(wr_q.size()), 32'd5);
        flush();

`ifdef TIMER_SEQ_CANCEL_EN
        // 6: cancel the owner in WAIT; the pending channel follows
        set_period(2, 32'd200);
        set_period(3, 32'd10);
        issue(4'b0100);
        tick(8);
        issue(4'b1000);
        @(posedge clk); #1;
        cancel = 4'b0100;
        @(posedge clk); #1;
        cancel = '0;
        wait_dones("can_done", 1, 300);
        tick(5);
        chk_wr("can_stop", 4, 3'd1, 16'h0008);
        chk_wr("can_clr", 5, 3'd0, 16'h0000);
        chk("can_ncanc", 32'(canc_ch_q.size()), 32'd1);
        chk("can_ch", (canc_ch_q.size() > 0) ? 32'(canc_ch_q[0]) : 32'd99, 32'd2);
        chk("can_next_ch", 32'(done_ch(0)), 32'd3);
        chk("can_ndone", 32'(done_ch_q.size()), 32'd1);
        flush();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
